// File: rtl/multicycle_alu_core.sv
// Multi-cycle RV32I/RV64I integer-ALU core (OP-IMM and OP).
// Instructions are fetched through a req/valid handshake and then executed
// in one cycle. Illegal encodings or out-of-range register indices stop the
// core in HALT until reset.
module multicycle_alu_core #(
  parameter int                  XLEN     = 32,
  parameter int                  NUM_REGS = 32,
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                illegal,
  output logic [31:0]         retired,
  input  logic [4:0]          dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  localparam int        SHW   = $clog2(XLEN);
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [31:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_retired;
  logic                r_halted;
  logic                r_illegal;
  // x0 is hard-wired to zero, so only x1..x(NUM_REGS-1) are stored.
  logic [XLEN-1:0]     r_regs [1:NUM_REGS-1];

  logic                w_imem_req;
  logic                w_latch_ir;
  logic                w_commit;
  logic                w_trap;
  logic                w_legal;

  // Instruction fields
  logic [6:0]          w_opcode;
  logic [4:0]          w_rd;
  logic [2:0]          w_funct3;
  logic [4:0]          w_rs1;
  logic [4:0]          w_rs2;
  logic [6:0]          w_funct7;
  logic                w_is_opimm;
  logic                w_is_op;
  logic [XLEN-1:0]     w_imm;

  logic [XLEN-1:0]     w_rs1_val;
  logic [XLEN-1:0]     w_rs2_val;
  logic [XLEN-1:0]     w_dbg_val;
  logic [XLEN-1:0]     w_op_b;
  logic [SHW-1:0]      w_shamt;
  logic [XLEN-1:0]     w_result;

  assign w_opcode   = r_ir[6:0];
  assign w_rd       = r_ir[11:7];
  assign w_funct3   = r_ir[14:12];
  assign w_rs1      = r_ir[19:15];
  assign w_rs2      = r_ir[24:20];
  assign w_funct7   = r_ir[31:25];
  assign w_is_opimm = (w_opcode == 7'b0010011);
  assign w_is_op    = (w_opcode == 7'b0110011);
  assign w_imm      = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_op_b     = w_is_op ? w_rs2_val : w_imm;
  assign w_shamt    = w_is_op ? w_rs2_val[SHW-1:0] : r_ir[20 +: SHW];

  // Register file read ports: rs1, rs2 and the debug port; x0 and
  // indices without a backing register read as zero.
  always_comb begin
    w_rs1_val = {XLEN{1'b0}};
    w_rs2_val = {XLEN{1'b0}};
    w_dbg_val = {XLEN{1'b0}};
    for (int k = 1; k < NUM_REGS; k++) begin
      w_rs1_val = (w_rs1 == 5'(k))    ? r_regs[k] : w_rs1_val;
      w_rs2_val = (w_rs2 == 5'(k))    ? r_regs[k] : w_rs2_val;
      w_dbg_val = (dbg_addr == 5'(k)) ? r_regs[k] : w_dbg_val;
    end
  end

  // Decode legality: opcode/funct fields, shift immediate encoding and
  // register index range (rs2 only matters for register-register ops).
  always_comb begin
    logic w_fields_ok;
    logic w_shimm_hi_ok;
    logic w_regs_ok;
    w_fields_ok   = 1'b0;
    w_shimm_hi_ok = (XLEN == 64) || (r_ir[25] == 1'b0);
    w_regs_ok     = ({1'b0, w_rd} < NREGS) && ({1'b0, w_rs1} < NREGS);
    if (w_is_opimm) begin
      case (w_funct3)
        3'b001:  w_fields_ok = (r_ir[31:26] == 6'b000000) && w_shimm_hi_ok;
        3'b101:  w_fields_ok = ((r_ir[31:26] == 6'b000000) ||
                                (r_ir[31:26] == 6'b010000)) && w_shimm_hi_ok;
        default: w_fields_ok = 1'b1;
      endcase
    end else if (w_is_op) begin
      w_fields_ok = (w_funct7 == 7'b0000000) ||
                    ((w_funct7 == 7'b0100000) &&
                     ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      w_regs_ok   = w_regs_ok && ({1'b0, w_rs2} < NREGS);
    end else begin
      w_fields_ok = 1'b0;
    end
    w_legal = w_fields_ok && w_regs_ok;
  end

  // ALU: funct3 selects the operation; bit 30 distinguishes SUB and SRA/SRAI.
  always_comb begin
    w_result = {XLEN{1'b0}};
    case (w_funct3)
      3'b000: begin
        if (w_is_op && r_ir[30]) begin
          w_result = w_rs1_val - w_op_b;
        end else begin
          w_result = w_rs1_val + w_op_b;
        end
      end
      3'b001: w_result = w_rs1_val << w_shamt;
      3'b010: w_result = {{(XLEN-1){1'b0}}, ($signed(w_rs1_val) < $signed(w_op_b))};
      3'b011: w_result = {{(XLEN-1){1'b0}}, (w_rs1_val < w_op_b)};
      3'b100: w_result = w_rs1_val ^ w_op_b;
      3'b101: begin
        if (r_ir[30]) begin
          w_result = $unsigned($signed(w_rs1_val) >>> w_shamt);
        end else begin
          w_result = w_rs1_val >> w_shamt;
        end
      end
      3'b110: w_result = w_rs1_val | w_op_b;
      3'b111: w_result = w_rs1_val & w_op_b;
      default: w_result = {XLEN{1'b0}};
    endcase
  end

  // Control FSM next-state and per-state strobes.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_latch_ir   = 1'b0;
    w_commit     = 1'b0;
    w_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_valid) begin
          w_latch_ir   = 1'b1;
          w_next_state = S_EXECUTE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_EXECUTE: begin
        if (w_legal) begin
          w_commit     = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_trap       = 1'b1;
          w_next_state = S_HALT;
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_HALT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Architectural control state: instruction register, pc, retire counter
  // and halt flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir      <= 32'd0;
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_latch_ir) begin
        r_ir <= imem_rdata;
      end
      if (w_commit) begin
        r_pc      <= r_pc + PC_WIDTH'(4);
        r_retired <= r_retired + 32'd1;
      end
      if (w_trap) begin
        r_halted  <= 1'b1;
        r_illegal <= 1'b1;
      end
    end
  end

  // Register file write-back; rd=x0 has no storage so its writes vanish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        r_regs[k] <= {XLEN{1'b0}};
      end
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (w_commit && (w_rd == 5'(k))) begin
          r_regs[k] <= w_result;
        end
      end
    end
  end

  assign imem_req  = w_imem_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign retired   = r_retired;
  assign dbg_data  = w_dbg_val;

endmodule
